// File: rtl/robot_sensor_sched.sv
// Round-robin trigger/echo poller for the ultrasonic sensors; reduces each full
// sweep to its minimum distance and hands that to the robot core with a strobe.
module robot_sensor_sched #(
  parameter int N_SENS  = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1000,
  parameter int GUARD   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [N_SENS-1:0]         echo_valid,
  input  logic [N_SENS*DW-1:0]      echo_dist,
  input  logic                      clr_err,
  output logic [N_SENS-1:0]         trig,
  output logic [$clog2(N_SENS)-1:0] sens_idx,
  output logic [DW-1:0]             dist_v,
  output logic                      dist_valid,
  output logic [N_SENS-1:0]         timeout_err
);
  // state   | meaning
  // S_IDLE  | not sweeping, waiting for en
  // S_TRIG  | one-cycle trigger pulse to sensor sens_idx
  // S_WAIT  | waiting for that sensor's echo, bounded by TIMEOUT cycles
  // S_GUARD | settling gap before next trigger; sweep result published at its end

  localparam int IW = $clog2(N_SENS);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_SENS - 1);
  localparam logic [TW-1:0] WAIT_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_GUARD} state_t;

  state_t              state;
  logic [TW-1:0]       wait_cnt;
  logic [GW-1:0]       guard_cnt;
  logic [DW-1:0]       run_min;
  logic [DW-1:0]       cur_dist;
  logic                cur_echo;
  logic [IW-1:0]       next_idx;
  logic [N_SENS-1:0]   next_trig;

  always_comb begin
    cur_dist = '0;
    for (int i = 0; i < N_SENS; i++)
      if (sens_idx == IW'(i)) cur_dist = echo_dist[i*DW +: DW];
  end

  assign cur_echo = echo_valid[sens_idx];
  assign next_idx = (sens_idx == LAST_IDX) ? '0 : sens_idx + IW'(1);

  always_comb begin
    next_trig = '0;
    next_trig[next_idx] = 1'b1;
  end

  // Timers are down-counters loaded on state entry; terminal count is zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      sens_idx    <= '0;
      trig        <= '0;
      wait_cnt    <= '0;
      guard_cnt   <= '0;
      run_min     <= '1;
      dist_v      <= '1;
      dist_valid  <= 1'b0;
      timeout_err <= '0;
    end else begin
      trig       <= '0;
      dist_valid <= 1'b0;
      // A timeout assignment later in this block overrides the clear for its bit.
      if (clr_err) timeout_err <= '0;
      case (state)
        S_IDLE: begin
          if (en) begin
            state    <= S_TRIG;
            sens_idx <= '0;
            trig     <= N_SENS'(1);
            run_min  <= '1;
          end
        end
        S_TRIG: begin
          state    <= S_WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (cur_echo) begin
            if (cur_dist < run_min) run_min <= cur_dist;
            state     <= S_GUARD;
            guard_cnt <= GUARD_LOAD;
          end else if (wait_cnt == '0) begin
            timeout_err[sens_idx] <= 1'b1;
            state     <= S_GUARD;
            guard_cnt <= GUARD_LOAD;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        S_GUARD: begin
          if (guard_cnt != '0) begin
            guard_cnt <= guard_cnt - GW'(1);
          end else begin
            if (sens_idx == LAST_IDX) begin
              dist_v     <= run_min;
              dist_valid <= 1'b1;
            end
            if (en) begin
              state    <= S_TRIG;
              sens_idx <= next_idx;
              trig     <= next_trig;
              if (next_idx == '0) run_min <= '1;
            end else begin
              // partial sweeps are dropped; the next enable restarts at sensor 0
              state    <= S_IDLE;
              sens_idx <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
